// File: rtl/oam_dma_ctrl_if.sv
// CPU-side and memory-side bus of the OAM DMA controller.
// master: the system (CPU + memory) side; slave: the DMA controller.
interface oam_dma_ctrl_if;
    typedef logic [15:0] addr_t;
    typedef logic [7:0]  data_t;

    addr_t cpu_addr;
    logic  cpu_wen;
    data_t cpu_wdata;
    data_t cpu_rdata;
    logic  cpu_wait;

    addr_t mem_r_addr;
    addr_t mem_w_addr;
    logic  mem_wen;
    data_t mem_w_data;
    data_t mem_r_data;

    modport master (
        output cpu_addr, cpu_wen, cpu_wdata, mem_r_data,
        input  cpu_rdata, cpu_wait, mem_r_addr, mem_w_addr, mem_wen, mem_w_data
    );

    modport slave (
        input  cpu_addr, cpu_wen, cpu_wdata, mem_r_data,
        output cpu_rdata, cpu_wait, mem_r_addr, mem_w_addr, mem_wen, mem_w_data
    );
endinterface

// File: rtl/oam_dma_ctrl.sv
// OAM DMA: copies DMA_LEN bytes from page src_hi to FE00, arbitrating the memory ports per phase.
// Define GB2_DMA_BUS_LOCK_EN to block non-HRAM CPU accesses while the DMA is busy.
module oam_dma_ctrl #(
    parameter int unsigned DMA_LEN      = 160,
    parameter logic [15:0] DMA_REG_ADDR = 16'hFF46
) (
    input  logic          clk,
    input  logic          rst,
    oam_dma_ctrl_if.slave bus,
    output logic          dma_busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DELAY = 2'd1;
    localparam logic [1:0] RD    = 2'd2;
    localparam logic [1:0] WR    = 2'd3;

    localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

    logic [1:0] state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] src_hi_q, src_hi_d;
    logic [7:0] byte_q, byte_d;
    logic       reg_sel;
    logic       reg_wr;
    logic       blocked;

    assign reg_sel  = bus.cpu_addr == DMA_REG_ADDR;
    assign reg_wr   = reg_sel && bus.cpu_wen;
    assign dma_busy = state_q != IDLE;

`ifdef GB2_DMA_BUS_LOCK_EN
    logic in_hram;
    assign in_hram = (bus.cpu_addr >= 16'hFF80) && (bus.cpu_addr <= 16'hFFFE);
    assign blocked = dma_busy && !in_hram && !reg_sel;
`else
    assign blocked = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        src_hi_d = src_hi_q;
        byte_d   = byte_q;
        case (state_q)
            DELAY: state_d = RD;
            RD: begin
                byte_d  = bus.mem_r_data;
                state_d = WR;
            end
            WR: begin
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = RD;
                end
            end
            default: state_d = state_q;
        endcase
        // A register write restarts the transfer from any state.
        if (reg_wr) begin
            src_hi_d = (bus.cpu_wdata > 8'hDF) ? (bus.cpu_wdata & 8'hDF) : bus.cpu_wdata;
            idx_d    = 8'h00;
            state_d  = DELAY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= 8'h00;
            src_hi_q <= 8'hFF;
            byte_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            src_hi_q <= src_hi_d;
            byte_q   <= byte_d;
        end
    end

    always_comb begin
        bus.mem_r_addr = bus.cpu_addr;
        bus.mem_w_addr = bus.cpu_addr;
        bus.mem_w_data = bus.cpu_wdata;
        bus.mem_wen    = bus.cpu_wen && !reg_sel && !blocked;
        bus.cpu_wait   = 1'b0;
        case (state_q)
            RD: begin
                bus.mem_r_addr = {src_hi_q, idx_q};
                bus.cpu_wait   = !bus.cpu_wen && !reg_sel && !blocked;
            end
            WR: begin
                bus.mem_w_addr = 16'hFE00 + {8'h00, idx_q};
                bus.mem_w_data = byte_q;
                bus.mem_wen    = 1'b1;
                bus.cpu_wait   = bus.cpu_wen && !reg_sel && !blocked;
            end
            default: bus.cpu_wait = 1'b0;
        endcase
    end

    always_comb begin
        if (reg_sel) begin
            bus.cpu_rdata = src_hi_q;
        end else if (blocked) begin
            bus.cpu_rdata = 8'hFF;
        end else begin
            bus.cpu_rdata = bus.mem_r_data;
        end
    end
endmodule

// File: doc/oam_dma_ctrl.md
OAM_DMA_CTRL -- requirements
Module: oam_dma_ctrl

Interface
REQ-001 SHALL have parameter DMA_LEN, default 160, meaning bytes per transfer (1..256).
REQ-002 SHALL have parameter DMA_REG_ADDR, default 16'hFF46, meaning the address of the DMA start/source register.
REQ-003 SHALL have ports: clk  in  1  system clock; rst  in  1  reset (one clock; synchronous, active-high).
REQ-004 SHALL have CPU-side ports: cpu_addr  in  addr_t  CPU address; cpu_wen  in  1  CPU write strobe; cpu_wdata  in  data_t  CPU write data; cpu_rdata  out  data_t  CPU read data; cpu_wait  out  1  CPU access not serviced this cycle, retry.
REQ-005 SHALL have memory-side ports: mem_r_addr  out  addr_t; mem_w_addr  out  addr_t; mem_wen  out  1; mem_w_data  out  data_t; mem_r_data  in  data_t (combinational read, write on posedge clk).
REQ-006 SHALL have status port dma_busy  out  1, meaning state != IDLE.

Function
REQ-007 SHALL implement states IDLE, DELAY, RD, WR with an 8-bit index idx and an 8-bit source register src_hi.
REQ-008 A CPU write with cpu_addr == DMA_REG_ADDR SHALL, in any state, load src_hi, clear idx, enter DELAY next cycle, never assert cpu_wait, and never be forwarded to memory.
REQ-009 If written value > 8'hDF, src_hi SHALL be loaded as value & 8'hDF (echo-RAM clamp).
REQ-010 DELAY SHALL last exactly one cycle, then go to RD.
REQ-011 RD: mem_r_addr = {src_hi, idx}; mem_r_data latched into byte buffer at clock edge; next state WR.
REQ-012 WR: mem_w_addr = 16'hFE00 + idx, mem_w_data = byte buffer, mem_wen = 1; if idx == DMA_LEN-1 go to IDLE, else idx+1 and go to RD.
REQ-013 A transfer SHALL take 1 + 2*DMA_LEN cycles from register write to return to IDLE (321 at default).
REQ-014 IDLE/DELAY: CPU SHALL own both memory ports (mem_r_addr = mem_w_addr = cpu_addr, mem_wen = cpu_wen, mem_w_data = cpu_wdata); cpu_wait = 0.
REQ-015 RD: DMA owns read port; CPU reads assert cpu_wait, CPU writes pass through write port.
REQ-016 WR: DMA owns write port; CPU writes assert cpu_wait and SHALL NOT reach memory, CPU reads pass through read port.
REQ-017 cpu_rdata SHALL equal src_hi when cpu_addr == DMA_REG_ADDR, else the blocked value per REQ-024, else mem_r_data.
REQ-018 cpu_wait and cpu_rdata SHALL be combinational from state and cpu_addr/cpu_wen; all other outputs combinational from registered state.
REQ-019 mem_wen SHALL never be asserted for a waited or blocked CPU write.

Reset
REQ-020 On rst high at clk edge: state = IDLE, idx = 0, src_hi = 8'hFF, byte buffer = 8'h00.
REQ-021 During/after reset: dma_busy = 0, cpu_wait = 0, mem_wen = cpu_wen; reset mid-transfer SHALL abort with no further DMA writes.

Configuration
REQ-022 Macro GB2_DMA_BUS_LOCK_EN SHALL select CPU lockout.
REQ-023 Undefined: REQ-014..016 apply to all CPU addresses.
REQ-024 Defined: while dma_busy, CPU accesses outside HRAM (16'hFF80..16'hFFFE) and outside DMA_REG_ADDR are blocked: reads return 8'hFF, writes dropped, cpu_wait = 0; HRAM accesses follow REQ-015/016.

Verification
REQ-025 Preload C000..C09F = 8'h00..8'h9F, write 8'hC0 to FF46 -> dma_busy 321 cycles, FE00..FE9F = 8'h00..8'h9F, FEA0 untouched.
REQ-026 Write 8'hF1 to FF46 -> source page D1, FF46 reads 8'hD1.
REQ-027 CPU read FF90 in RD cycle -> cpu_wait = 1; same read in WR -> cpu_wait = 0, data = mem[FF90]; CPU write FF90 in WR -> cpu_wait = 1, memory unchanged.
REQ-028 Rewrite FF46 = 8'hC1 at idx 50 -> idx restarts 0, FE00..FE9F end equal to C100..C19F, total busy 50*2+1+321 cycles.
REQ-029 Assert rst at idx 10 -> dma_busy 0 next cycle, FE0B..FE9F unchanged, FF46 reads 8'hFF.
REQ-030 With GB2_DMA_BUS_LOCK_EN, read C000 during DMA -> 8'hFF, cpu_wait 0; write 8'h55 to C000 -> mem[C000] unchanged; without macro -> phase-arbitrated per REQ-015/016.
